// File: rtl/dpll_trail_ctrl.sv
// -----------------------------------------------------------------------------
// dpll_trail_ctrl
//
// Sequencer for the DPLL assignment trail stack. Branching decisions become
// stack pushes. A conflict starts chronological backtracking: trail entries
// are popped until an unflipped decision turns up, and that decision is then
// pushed back with its flipped value. Every assign and unassign is reported
// to the clause evaluator. A sticky unsat is raised when the trail runs out.
//
// Handshakes: a request is taken on a rising edge where its valid and ready
// are both high. Ready depends only on registered state. A requester keeps
// valid and its payload stable until that edge. If a conflict and a decision
// are both valid, only the conflict is taken, so the decision must be held.
//
// Ports
//   clk, rst        clock, synchronous active-high reset (shared with stack)
//   dec_valid/ready decision handshake; dec_var, dec_val = decision payload
//   cfl_valid/ready conflict handshake
//   stk_push/pop    stack controls; stk_din = {flipped, var}, stk_bool = value
//   stk_dout(_bool) popped entry, valid in the cycle after the pop
//   asg_valid       one-cycle change strobe; asg_undo 1 = unassign
//   asg_var/val     variable and value of the change
//   depth           entries currently on the trail (own counter)
//   unsat           sticky, trail exhausted
//   busy            sequencing a push or a backtrack
// -----------------------------------------------------------------------------
module dpll_trail_ctrl #(
   parameter int VAR_W = 7,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   output logic                     dec_ready,
   input  logic [VAR_W-1:0]         dec_var,
   input  logic                     dec_val,
   input  logic                     cfl_valid,
   output logic                     cfl_ready,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic [VAR_W:0]           stk_din,
   output logic                     stk_bool,
   input  logic [VAR_W:0]           stk_dout,
   input  logic                     stk_dout_bool,
   output logic                     asg_valid,
   output logic                     asg_undo,
   output logic [VAR_W-1:0]         asg_var,
   output logic                     asg_val,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     unsat,
   output logic                     busy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PUSH  = 3'd1,
      POP   = 3'd2,
      CHK   = 3'd3,
      FLIP  = 3'd4,
      UNSAT = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    depth_q, depth_d;
   logic [VAR_W-1:0] var_q,   var_d;
   logic             val_q,   val_d;

   // Ready is decoded from registered state only, so accepting a request
   // never depends combinationally on the request itself.
   assign dec_ready = (state_q == IDLE) && (depth_q < DEPTH_MAX);
   assign cfl_ready = (state_q == IDLE);
   assign unsat     = (state_q == UNSAT);
   assign busy      = (state_q != IDLE) && (state_q != UNSAT);
   assign depth     = depth_q;

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      var_d     = var_q;
      val_d     = val_q;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_din   = '0;
      stk_bool  = 1'b0;
      asg_valid = 1'b0;
      asg_undo  = 1'b0;
      asg_var   = '0;
      asg_val   = 1'b0;

      case (state_q)
         IDLE: begin
            // Conflict wins over a simultaneous decision.
            if (cfl_valid && cfl_ready) begin
               state_d = (depth_q == '0) ? UNSAT : POP;
            end else if (dec_valid && dec_ready) begin
               state_d = PUSH;
               var_d   = dec_var;
               val_d   = dec_val;
            end
         end

         PUSH: begin
            stk_push  = 1'b1;
            stk_din   = {1'b0, var_q};
            stk_bool  = val_q;
            asg_valid = 1'b1;
            asg_var   = var_q;
            asg_val   = val_q;
            depth_d   = depth_q + 1'b1;
            state_d   = IDLE;
         end

         POP: begin
            stk_pop = 1'b1;
            depth_d = depth_q - 1'b1;
            state_d = CHK;
         end

         CHK: begin
            // The popped entry is on stk_dout now; this is the only
            // combinational path from the stack to the outputs.
            asg_valid = 1'b1;
            asg_undo  = 1'b1;
            asg_var   = stk_dout[VAR_W-1:0];
            asg_val   = stk_dout_bool;
            var_d     = stk_dout[VAR_W-1:0];
            val_d     = ~stk_dout_bool;
            if (!stk_dout[VAR_W]) begin
               state_d = FLIP;
            end else if (depth_q != '0) begin
               // Already-flipped entries are discarded, never re-flipped.
               state_d = POP;
            end else begin
               state_d = UNSAT;
            end
         end

         FLIP: begin
            // val_q already holds the inverted polarity latched in CHK.
            stk_push  = 1'b1;
            stk_din   = {1'b1, var_q};
            stk_bool  = val_q;
            asg_valid = 1'b1;
            asg_var   = var_q;
            asg_val   = val_q;
            depth_d   = depth_q + 1'b1;
            state_d   = IDLE;
         end

         UNSAT: begin
            state_d = UNSAT;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         depth_q <= '0;
         var_q   <= '0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         var_q   <= var_d;
         val_q   <= val_d;
      end
   end

endmodule
